perceptron_ctrl: RTL and testbench

//  Byte-stream command sequencer for one perceptron node. Sits between the UART RX/TX byte

---
 rtl/perceptron_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_perceptron_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/perceptron_ctrl.sv
// rtl/perceptron_ctrl.sv - byte-stream command sequencer for one perceptron node
//
// Purpose:
//    Decodes addressed frames [ADDR][OP][payload] from a UART RX byte stream,
//    loads operands D1/D2, sequences MUL / MUL-ADD on a shared multiplier and
//    returns the 32-bit accumulator over the UART TX byte interface.
//    OP 0: load D1, OP 1: load D2 (4 bytes, LSB first), OP 2: send acc,
//    OP 5: acc = D1*D2, OP 6: acc = acc + D1*D2.
//
// Configuration:
//    PERCEPTRON_CTRL_BCAST_EN - when defined, address 0xFF also matches; OP 2
//    under 0xFF is a no-op so that several nodes never drive TX at once.
//
// Ports:
//    clk        in   1   system clock, rising edge
//    nRst       in   1   asynchronous active-low reset
//    rx_byte    in   8   received UART byte
//    rx_valid   in   1   1-cycle strobe, rx_byte valid
//    tx_byte    out  8   byte to transmit, stable while tx_valid is high
//    tx_valid   out  1   tx_byte valid, held until accepted
//    tx_ready   in   1   UART TX can accept
//    mul_a      out  32  multiplier operand A (D1)
//    mul_b      out  32  multiplier operand B (D2)
//    mul_start  out  1   1-cycle multiply launch pulse
//    mul_done   in   1   1-cycle pulse, mul_p valid
//    mul_p      in   32  product, low 32 bits
//    acc        out  32  accumulator register
//    busy       out  1   high whenever the sequencer is not idle

module perceptron_ctrl #(
   parameter logic [7:0] NODE_ADDR = 8'd100,
   parameter int         TIMEOUT   = 500000
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic [7:0]  rx_byte,
   input  logic        rx_valid,
   output logic [7:0]  tx_byte,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [31:0] mul_a,
   output logic [31:0] mul_b,
   output logic        mul_start,
   input  logic        mul_done,
   input  logic [31:0] mul_p,
   output logic [31:0] acc,
   output logic        busy
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_OPCODE  = 3'd1;
   localparam logic [2:0] S_SKIP_OP = 3'd2;
   localparam logic [2:0] S_SKIP_PL = 3'd3;
   localparam logic [2:0] S_LOAD    = 3'd4;
   localparam logic [2:0] S_EXEC    = 3'd5;
   localparam logic [2:0] S_SEND    = 3'd6;

   localparam int              GW      = $clog2(TIMEOUT + 1);
   localparam logic [GW-1:0]   GAP_MAX = GW'(TIMEOUT - 1);

   logic [2:0]    r_state;
   logic [1:0]    r_cnt;
   logic [GW-1:0] r_gap;
   logic [31:0]   r_stage;
   logic [31:0]   r_d1;
   logic [31:0]   r_d2;
   logic [31:0]   r_acc;
   logic [31:0]   r_snap;
   logic          r_sel_d2;
   logic          r_op_add;
   logic          r_mul_start;
   logic          r_bcast;

   logic          w_addr_hit;
   logic          w_is_bcast;
   logic          w_timed;
   logic          w_timeout;
   logic          w_tx_fire;
   logic [31:0]   w_stage_next;
   logic [7:0]    w_snap_byte;

`ifdef PERCEPTRON_CTRL_BCAST_EN
   assign w_is_bcast = (rx_byte == 8'hFF);
   assign w_addr_hit = (rx_byte == NODE_ADDR) || w_is_bcast;
`else
   assign w_is_bcast = 1'b0;
   assign w_addr_hit = (rx_byte == NODE_ADDR);
`endif

   // Inter-byte gap timer only runs while a command is partially received.
   assign w_timed   = (r_state == S_OPCODE) || (r_state == S_SKIP_OP) ||
                      (r_state == S_SKIP_PL) || (r_state == S_LOAD);
   assign w_timeout = w_timed && !rx_valid && (r_gap == GAP_MAX);

   assign w_tx_fire    = tx_valid && tx_ready;
   assign w_stage_next = {rx_byte, r_stage[31:8]};

   always_comb begin
      w_snap_byte = 8'h00;
      case (r_cnt)
         2'd0: w_snap_byte = r_snap[7:0];
         2'd1: w_snap_byte = r_snap[15:8];
         2'd2: w_snap_byte = r_snap[23:16];
         2'd3: w_snap_byte = r_snap[31:24];
         default: w_snap_byte = 8'h00;
      endcase
   end

   assign tx_valid  = (r_state == S_SEND);
   assign tx_byte   = tx_valid ? w_snap_byte : 8'h00;
   assign mul_a     = r_d1;
   assign mul_b     = r_d2;
   assign mul_start = r_mul_start;
   assign acc       = r_acc;
   assign busy      = (r_state != S_IDLE);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         r_state     <= S_IDLE;
         r_cnt       <= 2'd0;
         r_gap       <= '0;
         r_stage     <= 32'd0;
         r_d1        <= 32'd0;
         r_d2        <= 32'd0;
         r_acc       <= 32'd0;
         r_snap      <= 32'd0;
         r_sel_d2    <= 1'b0;
         r_op_add    <= 1'b0;
         r_mul_start <= 1'b0;
         r_bcast     <= 1'b0;
      end else begin
         r_mul_start <= 1'b0;
         if (w_timed && !rx_valid) r_gap <= r_gap + 1'b1;
         else                      r_gap <= '0;

         case (r_state)
            S_IDLE: begin
               if (rx_valid) begin
                  r_state <= w_addr_hit ? S_OPCODE : S_SKIP_OP;
                  r_bcast <= w_is_bcast;
               end
            end
            S_OPCODE: begin
               if (rx_valid) begin
                  r_cnt <= 2'd0;
                  if (rx_byte == 8'd0 || rx_byte == 8'd1) begin
                     r_state  <= S_LOAD;
                     r_sel_d2 <= rx_byte[0];
                  end else if (rx_byte == 8'd5 || rx_byte == 8'd6) begin
                     r_state     <= S_EXEC;
                     r_op_add    <= (rx_byte == 8'd6);
                     r_mul_start <= 1'b1;
                  end else if (rx_byte == 8'd2 && !r_bcast) begin
                     r_state <= S_SEND;
                     r_snap  <= r_acc;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_SKIP_OP: begin
               if (rx_valid) begin
                  r_cnt   <= 2'd0;
                  r_state <= (rx_byte == 8'd0 || rx_byte == 8'd1) ? S_SKIP_PL : S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_SKIP_PL: begin
               if (rx_valid) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) r_state <= S_IDLE;
               end else if (w_timeout) begin
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (rx_valid) begin
                  r_stage <= w_stage_next;
                  r_cnt   <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) begin
                     if (r_sel_d2) r_d2 <= w_stage_next;
                     else          r_d1 <= w_stage_next;
                     r_state <= S_IDLE;
                  end
               end else if (w_timeout) begin
                  r_stage <= 32'd0;
                  r_state <= S_IDLE;
               end
            end
            S_EXEC: begin
               // A done pulse in the launch cycle cannot belong to this multiply.
               if (mul_done && !r_mul_start) begin
                  r_acc   <= r_op_add ? (r_acc + mul_p) : mul_p;
                  r_state <= S_IDLE;
               end
            end
            S_SEND: begin
               if (w_tx_fire) begin
                  r_cnt <= r_cnt + 2'd1;
                  if (r_cnt == 2'd3) r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_perceptron_ctrl.sv
// tb/tb_perceptron_ctrl.sv - testbench for perceptron_ctrl

module tb_perceptron_ctrl;

   localparam int TO = 300;

   logic        clk = 1'b0;
   logic        nRst = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_valid = 1'b0;
   logic [7:0]  tx_byte;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [31:0] mul_a;
   logic [31:0] mul_b;
   logic        mul_start;
   logic        mul_done = 1'b0;
   logic [31:0] mul_p = 32'd0;
   logic [31:0] acc;
   logic        busy;

   int checks = 0;
   int errors = 0;
   int starts = 0;
   int tx_seen = 0;

   perceptron_ctrl #(.NODE_ADDR(8'd100), .TIMEOUT(TO)) dut (
      .clk(clk), .nRst(nRst), .rx_byte(rx_byte), .rx_valid(rx_valid),
      .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
      .mul_done(mul_done), .mul_p(mul_p), .acc(acc), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (mul_start) starts++;
      if (tx_valid)  tx_seen++;
   end

   // Multiplier model: product returned four cycles after the launch pulse.
   initial begin : mul_model
      logic [31:0] ma, mb;
      forever begin
         @(negedge clk);
         if (mul_start) begin
            ma = mul_a;
            mb = mul_b;
            repeat (4) @(negedge clk);
            mul_p    = ma * mb;
            mul_done = 1'b1;
            @(negedge clk);
            mul_done = 1'b0;
         end
      end
   end

   typedef struct {
      logic [0:5][7:0] b;
      int              n;
      logic [31:0]     ea;
      logic [31:0]     eb;
      logic [31:0]     eacc;
      int              es;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [0:5][7:0] b, input int n);
      for (int i = 0; i < n; i++) send_byte(b[i]);
   endtask

   task automatic wait_idle(input string nm);
      for (int c = 0; c < 100 && busy; c++) @(negedge clk);
      chk(nm, {31'd0, busy}, 32'd0);
   endtask

   task automatic recv4(input string nm, input int stall, input logic [31:0] exp);
      logic [31:0] word;
      logic [7:0]  held;
      int          unstable;
      word = 32'd0;
      unstable = 0;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < 200 && !tx_valid; c++) @(negedge clk);
         if (!tx_valid) begin
            chk({nm, " tx_valid timeout"}, 32'd0, 32'd1);
            return;
         end
         held = tx_byte;
         for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!tx_valid || tx_byte !== held) unstable++;
         end
         word[8*k +: 8] = tx_byte;
         tx_ready = 1'b1;
         @(negedge clk);
         tx_ready = 1'b0;
      end
      chk({nm, " data"}, word, exp);
      chk({nm, " tx_valid drop"}, {31'd0, tx_valid}, 32'd0);
      if (stall > 0) chk({nm, " stable"}, unstable, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      nRst = 1'b0;
      repeat (2) @(negedge clk);
      nRst = 1'b1;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " tx_valid"},  {31'd0, tx_valid},  32'd0);
      chk({nm, " tx_byte"},   {24'd0, tx_byte},   32'd0);
      chk({nm, " mul_a"},     mul_a,              32'd0);
      chk({nm, " mul_b"},     mul_b,              32'd0);
      chk({nm, " mul_start"}, {31'd0, mul_start}, 32'd0);
      chk({nm, " acc"},       acc,                32'd0);
      chk({nm, " busy"},      {31'd0, busy},      32'd0);
   endtask

   initial begin
      int tx_before;

      vecs[0]  = '{{8'd100, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0}, 6, 32'd1, 32'd0, 32'd0, 0};
      vecs[1]  = '{{8'd100, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0}, 6, 32'd1, 32'd1, 32'd0, 0};
      vecs[2]  = '{{8'd100, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'd1, 32'd1, 32'd1, 1};
      vecs[3]  = '{{8'd100, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'd1, 32'd1, 32'd2, 2};
      vecs[4]  = '{{8'd101, 8'd0, 8'd7, 8'd7, 8'd7, 8'd7}, 6, 32'd1, 32'd1, 32'd2, 2};
      vecs[5]  = '{{8'd101, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'd1, 32'd1, 32'd2, 2};
      vecs[6]  = '{{8'd100, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'd1, 32'd1, 32'd2, 2};
      vecs[7]  = '{{8'd101, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'd1, 32'd1, 32'd2, 2};
      vecs[8]  = '{{8'd100, 8'd0, 8'h78, 8'h56, 8'h34, 8'h12}, 6, 32'h12345678, 32'd1, 32'd2, 2};
      vecs[9]  = '{{8'd100, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0}, 6, 32'h12345678, 32'd3, 32'd2, 2};
      vecs[10] = '{{8'd100, 8'd5, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'h12345678, 32'd3, 32'h369D0368, 3};
      vecs[11] = '{{8'd100, 8'd6, 8'd0, 8'd0, 8'd0, 8'd0}, 2, 32'h12345678, 32'd3, 32'h6D3A06D0, 4};

      // Reset state
      repeat (3) @(negedge clk);
      chk_zero("reset");
      nRst = 1'b1;

      // Frame table: loads, MAC ops, address filter, unknown opcode
      for (int i = 0; i < 12; i++) begin
         tx_before = tx_seen;
         send_frame(vecs[i].b, vecs[i].n);
         wait_idle($sformatf("v%0d idle", i));
         chk($sformatf("v%0d mul_a", i),  mul_a,   vecs[i].ea);
         chk($sformatf("v%0d mul_b", i),  mul_b,   vecs[i].eb);
         chk($sformatf("v%0d acc", i),    acc,     vecs[i].eacc);
         chk($sformatf("v%0d starts", i), starts,  vecs[i].es);
         chk($sformatf("v%0d no_tx", i),  tx_seen, tx_before);
      end

      // Read back accumulator
      send_byte(8'd100); send_byte(8'd2);
      recv4("send1", 0, 32'h6D3A06D0);

      // Gaps just under the timeout keep the command alive
      send_byte(8'd100); send_byte(8'd0); send_byte(8'hAA);
      repeat (TO - 20) @(negedge clk);
      send_byte(8'hBB); send_byte(8'hCC);
      repeat (TO - 20) @(negedge clk);
      send_byte(8'hDD);
      wait_idle("slow idle");
      chk("slow load", mul_a, 32'hDDCCBBAA);

      // Timeout aborts a partial load, D1 unchanged
      send_byte(8'd100); send_byte(8'd0); send_byte(8'd5); send_byte(8'd5);
      repeat (TO + 10) @(negedge clk);
      chk("timeout busy", {31'd0, busy}, 32'd0);
      chk("timeout d1", mul_a, 32'hDDCCBBAA);
      send_byte(8'd100); send_byte(8'd2);
      recv4("timeout send", 0, 32'h6D3A06D0);
      send_frame({8'd100, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4}, 6);
      wait_idle("reload idle");
      chk("reload d1", mul_a, 32'h04030201);

      // Wraparound accumulate and TX backpressure
      pulse_reset();
      send_frame({8'd100, 8'd0, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6);
      send_frame({8'd100, 8'd1, 8'hFF, 8'hFF, 8'hFF, 8'hFF}, 6);
      send_byte(8'd100); send_byte(8'd6); wait_idle("wrap1 idle");
      send_byte(8'd100); send_byte(8'd6); wait_idle("wrap2 idle");
      chk("wrap acc", acc, 32'h00000002);
      send_byte(8'd100); send_byte(8'd2);
      recv4("stall send", 50, 32'h00000002);

      // Bytes arriving during SEND are dropped
      send_byte(8'd100); send_byte(8'd2);
      send_frame({8'd100, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9}, 6);
      recv4("drop send", 0, 32'h00000002);
      wait_idle("drop idle");
      chk("drop d1", mul_a, 32'hFFFFFFFF);

      // Reset mid-SEND
      send_byte(8'd100); send_byte(8'd2);
      chk("midsend tx_valid", {31'd0, tx_valid}, 32'd1);
      #1 nRst = 1'b0;
      #1 chk_zero("rst send");
      repeat (2) @(negedge clk);
      nRst = 1'b1;

      // Reset mid-EXEC; the late mul_done must not touch acc
      send_frame({8'd100, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0}, 6);
      send_frame({8'd100, 8'd1, 8'd3, 8'd0, 8'd0, 8'd0}, 6);
      send_byte(8'd100); send_byte(8'd5);
      chk("midexec busy", {31'd0, busy}, 32'd1);
      #2 nRst = 1'b0;
      #1 chk_zero("rst exec");
      repeat (2) @(negedge clk);
      nRst = 1'b1;
      repeat (10) @(negedge clk);
      chk("late done acc", acc, 32'd0);
      chk("late done busy", {31'd0, busy}, 32'd0);
      send_frame({8'd100, 8'd0, 8'd4, 8'd0, 8'd0, 8'd0}, 6);
      wait_idle("post rst idle");
      chk("post rst d1", mul_a, 32'd4);
      chk("post rst d2", mul_b, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

endmodule
